dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences MEM-stage loads/stores onto the sram-like data bus (req/addr_ok/data_ok).
//  Checks alignment (lh/lhu/sh: addr[0]; lw/sw: addr[1:0]) and reports adel/ades with bad_addr.
//  Sizes and replicates store data, sign/zero-extends load data and raises stall_req while a
//  transfer is outstanding. Sits between the MEM stage and the data-side AXI bridge.
// PARAMETERS
//  KSEG_MASK  32'h1FFF_FFFF  mask applied to kseg0/kseg1 addresses when DSRAM_ADDR_MAP_EN is defined
// PORTS
//  clk             in   1   clock
//  resetn          in   1   asynchronous active-low reset
//  mem_en          in   1   valid load/store in MEM stage
//  op              in   6   opcode (EXE_LB/LBU/LH/LHU/LW/SB/SH/SW from defines.vh)
//  pc              in   32  PC of the MEM-stage instruction
//  addr            in   32  effective address (aluoutM)
//  wdata_in        in   32  store source (rt)
//  flush           in   1   exception/pipeline flush, kills the MEM-stage access
//  pipe_adv        in   1   pipeline advances this cycle (no stall elsewhere)
//  adelM / adesM   out  1   load / store address error (combinational)
//  bad_addr        out  32  addr on misaligned access, else pc
//  stall_req       out  1   hold the pipeline
//  rdata_out       out  32  extended load result, valid in DONE
//  data_req        out  1   sram-like request
//  data_wr         out  1   1 = store
//  data_size       out  2   0 byte, 1 half, 2 word
//  data_addr       out  32  bus address
//  data_wdata      out  32  replicated store data
//  data_addr_ok    in   1   request accepted
//  data_data_ok    in   1   read data / write ack returned
//  data_rdata      in   32  read data
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, cancel=0, latched op/addr/wdata=0, rdata_out=0;
//    data_req=0, stall_req=0. Combinational outputs follow inputs.
//  - addr_err = adelM|adesM. start = IDLE & mem_en & ~addr_err & ~flush.
//  - IDLE: on start latch op, addr, wdata_in; next REQ. Misaligned or flushed: no request, stay IDLE.
//  - REQ: data_req=1; wr/size/addr/wdata from latched copies, stable until addr_ok.
//    On addr_ok go WAIT (data_req=0 next cycle). A request is never withdrawn.
//  - WAIT: on data_ok: if cancel, go IDLE and discard; else capture extended data_rdata into
//    rdata_out (stores capture nothing) and go DONE.
//  - DONE: hold rdata_out; on pipe_adv or flush go IDLE. No re-issue for the same instruction.
//  - stall_req = start | REQ | WAIT (combinational, start included so the issue cycle stalls).
//  - flush in REQ or WAIT sets cancel; cancel clears on entering IDLE. addr_ok and data_ok in
//    the same cycle as entry to WAIT are not possible (data_ok only counts in WAIT).
//  - Load extension: LB/LBU byte at addr[1:0]; LH/LHU half at addr[1]; LB/LH sign-extend,
//    LBU/LHU zero-extend; LW passthrough.
//  - Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata. Size from op.
//  - Unknown op with mem_en: no error, no request, treated as no-op.
// CONFIGURATION
//  DSRAM_ADDR_MAP_EN defined: data_addr = (addr[31:30]==2'b10) ? addr & KSEG_MASK : addr
//  (kseg0/kseg1 to physical). Undefined: data_addr = latched addr unchanged; KSEG_MASK unused.
// TESTING
//  1 LW addr 8000_0010, addr_ok after 2 cyc, data_ok 3 cyc later, rdata DEADBEEF -> req held
//    till addr_ok, stall_req high through data_ok cycle, rdata_out=DEADBEEF, data_addr
//    0000_0010 (macro on) / 8000_0010 (off).
//  2 rdata 8001_0080: LB addr ..3 -> FFFF_FF80; LBU ..0 -> 0000_0080; LH ..2 -> FFFF_8001;
//    LHU ..2 -> 0000_8001.
//  3 SW addr ..2 -> adesM=1, bad_addr=addr, data_req never 1, stall_req=0; LH addr ..1 ->
//    adelM=1; LW aligned -> bad_addr=pc.
//  4 SB wdata 1234_5678 addr ..1 -> data_wr=1, size=0, data_wdata=7878_7878; SH -> 5678_5678.
//  5 flush while in REQ -> req held until addr_ok, data_ok discarded, rdata_out unchanged,
//    back to IDLE; flush in WAIT -> same discard; next access issues normally.
//  6 resetn low mid-WAIT -> immediately data_req=0, stall_req=0, state IDLE, rdata_out=0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store sequencer for an sram-like data bus.
// It checks alignment, sizes and replicates store data, extends load data and
// raises stall_req while a transfer is outstanding.
// Optional feature macro: DSRAM_ADDR_MAP_EN maps kseg0/kseg1 addresses to
// physical addresses with KSEG_MASK. Without the macro the address is unchanged.
module dmem_access_ctrl #(
    parameter logic [31:0] KSEG_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic [5:0]  op,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    input  logic        flush,
    input  logic        pipe_adv,
    output logic        adelM,
    output logic        adesM,
    output logic [31:0] bad_addr,
    output logic        stall_req,
    output logic [31:0] rdata_out,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam logic [5:0] EXE_LB  = 6'b100000;
    localparam logic [5:0] EXE_LH  = 6'b100001;
    localparam logic [5:0] EXE_LW  = 6'b100011;
    localparam logic [5:0] EXE_LBU = 6'b100100;
    localparam logic [5:0] EXE_LHU = 6'b100101;
    localparam logic [5:0] EXE_SB  = 6'b101000;
    localparam logic [5:0] EXE_SH  = 6'b101001;
    localparam logic [5:0] EXE_SW  = 6'b101011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        cancel_q, cancel_d;
    logic        req_q, req_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        known_op;
    logic        addr_err;
    logic        start;

    // Byte/half selection by address, followed by sign or zero extension.
    function automatic logic [31:0] ext_load(input logic [5:0] o, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (o)
            EXE_LB:  ext_load = {{24{b[7]}}, b};
            EXE_LBU: ext_load = {24'h0, b};
            EXE_LH:  ext_load = {{16{h[15]}}, h};
            EXE_LHU: ext_load = {16'h0, h};
            default: ext_load = rd;
        endcase
    endfunction

    // Decode the MEM-stage opcode, alignment errors and the issue condition.
    always_comb begin
        known_op = (op == EXE_LB) || (op == EXE_LBU) || (op == EXE_LH) || (op == EXE_LHU) ||
                   (op == EXE_LW) || (op == EXE_SB)  || (op == EXE_SH) || (op == EXE_SW);
        adelM    = mem_en && ((((op == EXE_LH) || (op == EXE_LHU)) && addr[0]) ||
                              ((op == EXE_LW) && (addr[1:0] != 2'b00)));
        adesM    = mem_en && (((op == EXE_SH) && addr[0]) ||
                              ((op == EXE_SW) && (addr[1:0] != 2'b00)));
        addr_err = adelM || adesM;
        bad_addr = addr_err ? addr : pc;
        start    = (state_q == S_IDLE) && mem_en && known_op && !addr_err && !flush;
        stall_req = start || (state_q == S_REQ) || (state_q == S_WAIT);
    end

    // Next-state logic for the transfer sequencer and its latched operands.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        req_d    = req_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (start) begin
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata_in;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The request stays up even when flushed; only the result is dropped.
                if (flush) cancel_d = 1'b1;
                if (data_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) cancel_d = 1'b1;
                if (data_data_ok) begin
                    if (cancel_q || flush) begin
                        cancel_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        if (op_q[3] == 1'b0) rdata_d = ext_load(op_q, addr_q[1:0], data_rdata);
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                if (pipe_adv || flush) begin
                    cancel_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
            req_q    <= 1'b0;
            op_q     <= 6'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            req_q    <= req_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Bus-side views of the latched operation.
    always_comb begin
        data_req  = req_q;
        rdata_out = rdata_q;
        data_wr   = op_q[3];
        case (op_q[1:0])
            2'b00:   data_size = 2'd0;
            2'b01:   data_size = 2'd1;
            default: data_size = 2'd2;
        endcase
        case (op_q[1:0])
            2'b00:   data_wdata = {4{wdata_q[7:0]}};
            2'b01:   data_wdata = {2{wdata_q[15:0]}};
            default: data_wdata = wdata_q;
        endcase
`ifdef DSRAM_ADDR_MAP_EN
        data_addr = (addr_q[31:30] == 2'b10) ? (addr_q & KSEG_MASK) : addr_q;
`else
        data_addr = addr_q;
`endif
    end

`ifndef DSRAM_ADDR_MAP_EN
    wire unused_kseg = ^KSEG_MASK;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed bench for dmem_access_ctrl with a scoreboard
// queue holding the expected rdata_out of each access.
module tb_dmem_access_ctrl;

    localparam logic [5:0] EXE_LB  = 6'b100000;
    localparam logic [5:0] EXE_LH  = 6'b100001;
    localparam logic [5:0] EXE_LW  = 6'b100011;
    localparam logic [5:0] EXE_LBU = 6'b100100;
    localparam logic [5:0] EXE_LHU = 6'b100101;
    localparam logic [5:0] EXE_SB  = 6'b101000;
    localparam logic [5:0] EXE_SH  = 6'b101001;
    localparam logic [5:0] EXE_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        flush;
    logic        pipe_adv;
    logic        adelM, adesM;
    logic [31:0] bad_addr;
    logic        stall_req;
    logic [31:0] rdata_out;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    dmem_access_ctrl dut (
        .clk(clk), .resetn(resetn), .mem_en(mem_en), .op(op), .pc(pc), .addr(addr),
        .wdata_in(wdata_in), .flush(flush), .pipe_adv(pipe_adv),
        .adelM(adelM), .adesM(adesM), .bad_addr(bad_addr), .stall_req(stall_req),
        .rdata_out(rdata_out), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bus_addr(input logic [31:0] a);
`ifdef DSRAM_ADDR_MAP_EN
        bus_addr = (a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
`else
        bus_addr = a;
`endif
    endfunction

    // One complete access. flush_at: 0 none, 1 during REQ, 2 during WAIT.
    task automatic access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] exp_rd,
                          input logic exp_wr, input logic [1:0] exp_sz,
                          input logic [31:0] exp_wd, input int ao_lat, input int do_lat,
                          input int flush_at, input string tag);
        int n;
        logic [31:0] exp;
        @(negedge clk);
        mem_en = 1'b1; op = o; addr = a; wdata_in = wd;
        sb_q.push_back(exp_rd);
        #1 chk({tag, "_issue_stall"}, {31'h0, stall_req}, 32'h1);
        @(negedge clk);
        n = 0;
        while (!data_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, {31'h0, data_req}, 32'h1);
        chk({tag, "_wr"}, {31'h0, data_wr}, {31'h0, exp_wr});
        chk({tag, "_size"}, {30'h0, data_size}, {30'h0, exp_sz});
        chk({tag, "_addr"}, data_addr, bus_addr(a));
        if (exp_wr) chk({tag, "_wdata"}, data_wdata, exp_wd);
        if (flush_at == 1) begin
            flush = 1'b1; mem_en = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            chk({tag, "_req_held_flush"}, {31'h0, data_req}, 32'h1);
        end
        for (int i = 0; i < ao_lat; i++) @(negedge clk);
        if (ao_lat > 0) chk({tag, "_req_held"}, {31'h0, data_req}, 32'h1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk({tag, "_req_drop"}, {31'h0, data_req}, 32'h0);
        chk({tag, "_wait_stall"}, {31'h0, stall_req}, 32'h1);
        if (flush_at == 2) begin
            flush = 1'b1; mem_en = 1'b0;
            @(negedge clk);
            flush = 1'b0;
        end
        for (int i = 1; i < do_lat; i++) @(negedge clk);
        data_data_ok = 1'b1; data_rdata = rd;
        #1 chk({tag, "_dok_stall"}, {31'h0, stall_req}, 32'h1);
        @(negedge clk);
        data_data_ok = 1'b0; data_rdata = 32'h0;
        chk({tag, "_done_stall"}, {31'h0, stall_req}, 32'h0);
        exp = sb_q.pop_front();
        chk({tag, "_rdata"}, rdata_out, exp);
        pipe_adv = 1'b1; mem_en = 1'b0;
        @(negedge clk);
        pipe_adv = 1'b0;
        chk({tag, "_rdata_hold"}, rdata_out, exp);
    endtask

    initial begin
        resetn = 1'b0; mem_en = 1'b0; op = 6'h0; pc = 32'hBFC0_0100; addr = 32'h0;
        wdata_in = 32'h0; flush = 1'b0; pipe_adv = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, data_req}, 32'h0);
        chk("rst_stall", {31'h0, stall_req}, 32'h0);
        chk("rst_rdata", rdata_out, 32'h0);
        resetn = 1'b1;

        // Word load through kseg0
        access(EXE_LW, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2'd2,
               32'h0, 1, 3, 0, "lw");

        // Load extension
        access(EXE_LB,  32'h0000_0103, 32'h0, 32'h8001_0080, 32'hFFFF_FF80, 1'b0, 2'd0,
               32'h0, 0, 1, 0, "lb");
        access(EXE_LBU, 32'h0000_0100, 32'h0, 32'h8001_0080, 32'h0000_0080, 1'b0, 2'd0,
               32'h0, 0, 2, 0, "lbu");
        access(EXE_LH,  32'h0000_0102, 32'h0, 32'h8001_0080, 32'hFFFF_8001, 1'b0, 2'd1,
               32'h0, 2, 1, 0, "lh");
        access(EXE_LHU, 32'h0000_0102, 32'h0, 32'h8001_0080, 32'h0000_8001, 1'b0, 2'd1,
               32'h0, 0, 1, 0, "lhu");

        // Alignment errors
        @(negedge clk);
        mem_en = 1'b1; op = EXE_SW; addr = 32'h0000_0202; wdata_in = 32'h1111_2222;
        #1;
        chk("sw_ades", {31'h0, adesM}, 32'h1);
        chk("sw_adel", {31'h0, adelM}, 32'h0);
        chk("sw_bad_addr", bad_addr, 32'h0000_0202);
        chk("sw_err_stall", {31'h0, stall_req}, 32'h0);
        repeat (3) @(negedge clk);
        chk("sw_err_noreq", {31'h0, data_req}, 32'h0);
        op = EXE_LH; addr = 32'h0000_0301;
        #1;
        chk("lh_adel", {31'h0, adelM}, 32'h1);
        chk("lh_bad_addr", bad_addr, 32'h0000_0301);
        op = EXE_LW; addr = 32'h0000_0304;
        #1;
        chk("lw_ok_adel", {31'h0, adelM}, 32'h0);
        chk("lw_ok_bad_addr", bad_addr, 32'hBFC0_0100);
        // Unknown opcode is a no-op
        op = 6'b000000; addr = 32'h0000_0001;
        #1;
        chk("nop_err", {30'h0, adelM, adesM}, 32'h0);
        chk("nop_stall", {31'h0, stall_req}, 32'h0);
        @(negedge clk);
        chk("nop_noreq", {31'h0, data_req}, 32'h0);
        mem_en = 1'b0;

        // Stores: rdata_out keeps the last load result
        access(EXE_SB, 32'h0000_0401, 32'h1234_5678, 32'h0, 32'h0000_8001, 1'b1, 2'd0,
               32'h7878_7878, 0, 1, 0, "sb");
        access(EXE_SH, 32'h0000_0402, 32'h1234_5678, 32'h0, 32'h0000_8001, 1'b1, 2'd1,
               32'h5678_5678, 1, 1, 0, "sh");

        // Flushed accesses: result discarded, then normal issue
        access(EXE_LW, 32'h0000_0500, 32'h0, 32'hAAAA_5555, 32'h0000_8001, 1'b0, 2'd2,
               32'h0, 1, 2, 1, "fl_req");
        access(EXE_LW, 32'h0000_0504, 32'h0, 32'h5555_AAAA, 32'h0000_8001, 1'b0, 2'd2,
               32'h0, 0, 2, 2, "fl_wait");
        access(EXE_LW, 32'hA000_0600, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2'd2,
               32'h0, 0, 1, 0, "after_fl");

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        mem_en = 1'b1; op = EXE_LW; addr = 32'h0000_0700;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("rstw_in_wait", {31'h0, stall_req}, 32'h1);
        #2;
        resetn = 1'b0; mem_en = 1'b0;
        #1;
        chk("rstw_req", {31'h0, data_req}, 32'h0);
        chk("rstw_stall", {31'h0, stall_req}, 32'h0);
        chk("rstw_rdata", rdata_out, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        chk("rstw_queue_empty", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
